prng_lfsr_core: RTL and testbench

- Random-number source that feeds the two-digit hex display stage; its byte output drives the HEX1 (upper nibble) and HEX0 (lower nibble) decoders.
- Contains a clock divider that produces a slow step tick and the clk1hz square wave, plus an 8-bit Galois LFSR that advances once per tick while enabled.
- Supports seed load and a freeze (hold) input so the displayed value can be held.

---
 rtl/prng_lfsr_core_pkg.sv | 19 +
 rtl/prng_lfsr_core_if.sv | 22 ++
 rtl/prng_lfsr_core_tick_div.sv | 43 ++++
 rtl/prng_lfsr_core.sv | 74 +++++++
 tb/tb_prng_lfsr_core.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/prng_lfsr_core_pkg.sv
// Shared definitions for the PRNG core: defaults, FSM state type and the Galois LFSR step.
package prng_pkg;

  localparam int             WIDTH_DEF = 8;
  localparam logic [7:0]     TAPS_DEF  = 8'hB8;
  localparam logic [7:0]     SEED_DEF  = 8'h01;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  // Right-shift Galois step; callers zero-extend narrower states so the top bits stay clear.
  function automatic logic [31:0] lfsr_next(input logic [31:0] state, input logic [31:0] taps);
    return (state >> 1) ^ (state[0] ? taps : 32'd0);
  endfunction

endpackage

// File: rtl/prng_lfsr_core_if.sv
// Control and result signals of the PRNG core; master drives controls, slave is the core.
interface prng_lfsr_core_if #(
  parameter int WIDTH = 8
);
  logic             EN;
  logic             hold;
  logic             seed_load;
  logic [WIDTH-1:0] seed_in;
  logic [WIDTH-1:0] rnd;
  logic             rnd_valid;
  logic             clk1hz;

  modport master (
    output EN, hold, seed_load, seed_in,
    input  rnd, rnd_valid, clk1hz
  );

  modport slave (
    input  EN, hold, seed_load, seed_in,
    output rnd, rnd_valid, clk1hz
  );
endinterface

// File: rtl/prng_lfsr_core_tick_div.sv
// Step-tick divider and clk1hz square wave generator.
// Macro PRNG_DIV_BYPASS_EN: when defined, tick = EN every cycle and DIV is ignored.
module prng_tick_div #(
  parameter int DIV = 50000000
) (
  input  logic CLK,
  input  logic reset,
  input  logic EN,
  output logic tick,
  output logic clk1hz
);

`ifdef PRNG_DIV_BYPASS_EN
  assign tick = EN;
`else
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count;

  assign tick = EN && (count == LAST);

  // Dropping EN restarts the period so the first tick is a full DIV cycles away.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (!EN || count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end
`endif

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      clk1hz <= 1'b0;
    end else if (tick) begin
      clk1hz <= ~clk1hz;
    end
  end

endmodule

// File: rtl/prng_lfsr_core.sv
// 8-bit Galois LFSR random source for the hex display, stepped by a divided tick.
//   state  | meaning
//   S_IDLE | EN low, no stepping
//   S_RUN  | stepping on every tick
//   S_HOLD | frozen by hold, ticks dropped
module prng_lfsr_core
  import prng_pkg::*;
#(
  parameter int               WIDTH = WIDTH_DEF,
  parameter int               DIV   = 50000000,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(TAPS_DEF),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(SEED_DEF)
) (
  input  logic               CLK,
  input  logic               reset,
  prng_lfsr_core_if.slave    bus
);

  state_t           state;
  logic [WIDTH-1:0] rnd_q;
  logic [WIDTH-1:0] rnd_next;
  logic             rnd_valid_q;
  logic             tick;
  logic             clk1hz;
  logic             step;

  prng_tick_div #(.DIV(DIV)) u_div (
    .CLK    (CLK),
    .reset  (reset),
    .EN     (bus.EN),
    .tick   (tick),
    .clk1hz (clk1hz)
  );

  assign rnd_next = WIDTH'(lfsr_next(32'(rnd_q), 32'(TAPS)));
  // hold gates the tick directly so a tick landing on the cycle hold rises is already dropped.
  assign step     = tick && !bus.hold && (state != S_IDLE);

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      rnd_q       <= SEED;
      rnd_valid_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (bus.EN) state <= S_RUN;
        S_RUN: begin
          if (!bus.EN)       state <= S_IDLE;
          else if (bus.hold) state <= S_HOLD;
        end
        S_HOLD: begin
          if (!bus.EN)        state <= S_IDLE;
          else if (!bus.hold) state <= S_RUN;
        end
        default: state <= S_IDLE;
      endcase

      rnd_valid_q <= 1'b0;
      // A load beats a coincident step; zero seeds map to SEED to avoid the lockup state.
      if (bus.seed_load) begin
        rnd_q       <= (bus.seed_in == '0) ? SEED : bus.seed_in;
        rnd_valid_q <= 1'b1;
      end else if (step) begin
        rnd_q       <= rnd_next;
        rnd_valid_q <= 1'b1;
      end
    end
  end

  assign bus.rnd       = rnd_q;
  assign bus.rnd_valid = rnd_valid_q;
  assign bus.clk1hz    = clk1hz;

endmodule

// File: tb/tb_prng_lfsr_core.sv
// Self-checking bench for prng_lfsr_core: directed scenarios plus randomized traffic vs a cycle model.
module tb_prng_lfsr_core;

  localparam int W   = 8;
  localparam int DIV = 4;

  logic CLK = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  prng_lfsr_core_if #(.WIDTH(W)) bus ();

  prng_lfsr_core #(
    .WIDTH (W),
    .DIV   (DIV),
    .TAPS  (8'hB8),
    .SEED  (8'h01)
  ) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  // reference model state: value shown, valid pulse, square wave, cycles of EN since it rose
  logic [7:0] m_rnd;
  logic       m_valid;
  logic       m_clk;
  int         m_run;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] galois(input logic [7:0] v);
    return (v / 8'd2) ^ ((v % 8'd2) != 0 ? 8'hB8 : 8'h00);
  endfunction

  task automatic model_reset();
    m_rnd = 8'h01; m_valid = 1'b0; m_clk = 1'b0; m_run = 0;
  endtask

  task automatic model_edge();
    logic tk;
    tk = bus.EN && ((m_run % DIV) == DIV - 1);
    m_valid = bus.seed_load || (tk && !bus.hold);
    if (bus.seed_load)          m_rnd = (bus.seed_in == 8'h00) ? 8'h01 : bus.seed_in;
    else if (tk && !bus.hold)   m_rnd = galois(m_rnd);
    if (tk) m_clk = ~m_clk;
    m_run = bus.EN ? m_run + 1 : 0;
  endtask

  task automatic cycle();
    @(posedge CLK);
    model_edge();
    #1;
    check("rnd", bus.rnd, m_rnd);
    check("rnd_valid", bus.rnd_valid, m_valid);
    check("clk1hz", bus.clk1hz, m_clk);
  endtask

  int          vcyc[$];
  logic [7:0]  vval[$];
  logic        prev_clk;
  int          toggles;
  logic [7:0]  frozen;
  logic        got;
  int          first_at;
  bit          seen[256];
  int          distinct;
  logic        zero_seen;
  logic [7:0]  last_val;
  int          nticks;

  initial begin
    reset = 1'b1;
    bus.EN = 1'b0; bus.hold = 1'b0; bus.seed_load = 1'b0; bus.seed_in = 8'h00;
    model_reset();
    #12;
    reset = 1'b0;
    check("reset_rnd", bus.rnd, 8'h01);
    check("reset_valid", bus.rnd_valid, 1'b0);
    check("reset_clk1hz", bus.clk1hz, 1'b0);
    repeat (20) cycle();
    check("idle_rnd", bus.rnd, 8'h01);
    check("idle_clk1hz", bus.clk1hz, 1'b0);

    // EN high from cycle 1: after edge c the bench is looking at cycle c+1
    bus.EN = 1'b1;
    prev_clk = bus.clk1hz;
    toggles = 0;
    for (int c = 1; c <= 22; c++) begin
      cycle();
      if (bus.rnd_valid) begin vcyc.push_back(c + 1); vval.push_back(bus.rnd); end
      if (bus.clk1hz != prev_clk) begin
        toggles++;
        check("clk_toggle_with_tick", bus.rnd_valid, 1'b1);
      end
      prev_clk = bus.clk1hz;
    end
    check("run_pulse_count", vcyc.size(), 5);
    check("run_toggles", toggles, 5);
    if (vcyc.size() == 5) begin
      check("run_v0_cyc", vcyc[0], 5);  check("run_v0", vval[0], 8'hB8);
      check("run_v1_cyc", vcyc[1], 9);  check("run_v1", vval[1], 8'h5C);
      check("run_v2_cyc", vcyc[2], 13); check("run_v2", vval[2], 8'h2E);
      check("run_v3_cyc", vcyc[3], 17); check("run_v3", vval[3], 8'h17);
      check("run_v4_cyc", vcyc[4], 21); check("run_v4", vval[4], 8'hB3);
    end

    // hold across three ticks
    bus.hold = 1'b1;
    frozen = bus.rnd;
    toggles = 0;
    got = 1'b0;
    prev_clk = bus.clk1hz;
    repeat (12) begin
      cycle();
      if (bus.rnd_valid) got = 1'b1;
      if (bus.clk1hz != prev_clk) toggles++;
      prev_clk = bus.clk1hz;
    end
    check("hold_frozen", bus.rnd, frozen);
    check("hold_no_valid", got, 1'b0);
    check("hold_toggles", toggles, 3);
    bus.hold = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 2 * DIV && !got; k++) begin
      cycle();
      if (bus.rnd_valid) got = 1'b1;
    end
    check("release_got_tick", got, 1'b1);
    check("release_one_step", bus.rnd, 8'hE1);

    // zero seed maps to the reset seed
    bus.seed_load = 1'b1; bus.seed_in = 8'h00;
    cycle();
    bus.seed_load = 1'b0;
    check("seed0_rnd", bus.rnd, 8'h01);
    check("seed0_valid", bus.rnd_valid, 1'b1);

    // load coincident with a tick
    for (int k = 0; k < 2 * DIV && (m_run % DIV) != DIV - 1; k++) cycle();
    check("align_tick", m_run % DIV, DIV - 1);
    bus.seed_load = 1'b1; bus.seed_in = 8'h5A;
    cycle();
    bus.seed_load = 1'b0;
    check("seed_tick_rnd", bus.rnd, 8'h5A);
    check("seed_tick_valid", bus.rnd_valid, 1'b1);
    cycle();
    check("seed_tick_single", bus.rnd_valid, 1'b0);
    got = 1'b0;
    for (int k = 0; k < 2 * DIV && !got; k++) begin
      cycle();
      if (bus.rnd_valid) got = 1'b1;
    end
    check("after_seed_got_tick", got, 1'b1);
    check("after_seed_step", bus.rnd, 8'h2D);

    // asynchronous reset in S_RUN at count 2
    for (int k = 0; k < 2 * DIV && (m_run % DIV) != 2; k++) cycle();
    check("align_cnt2", m_run % DIV, 2);
    #1 reset = 1'b1;
    #1;
    check("async_rst_rnd", bus.rnd, 8'h01);
    check("async_rst_valid", bus.rnd_valid, 1'b0);
    check("async_rst_clk1hz", bus.clk1hz, 1'b0);
    @(negedge CLK);
    reset = 1'b0;
    model_reset();
    first_at = 0;
    for (int k = 1; k <= 8; k++) begin
      cycle();
      if (bus.rnd_valid && first_at == 0) first_at = k;
    end
    check("post_rst_first_tick", first_at, DIV);

    // full period from seed 0x01
    bus.seed_load = 1'b1; bus.seed_in = 8'h01;
    cycle();
    bus.seed_load = 1'b0;
    for (int i = 0; i < 256; i++) seen[i] = 1'b0;
    distinct = 0; zero_seen = 1'b0; nticks = 0; last_val = 8'h00;
    for (int k = 0; k < 255 * DIV + 10 && nticks < 255; k++) begin
      cycle();
      if (bus.rnd_valid) begin
        nticks++;
        last_val = bus.rnd;
        if (bus.rnd == 8'h00) zero_seen = 1'b1;
        if (!seen[bus.rnd]) begin seen[bus.rnd] = 1'b1; distinct++; end
        if (nticks < 255 && bus.rnd == 8'h01) check("period_early_return", nticks, 255);
      end
    end
    check("period_ticks", nticks, 255);
    check("period_return", last_val, 8'h01);
    check("period_no_zero", zero_seen, 1'b0);
    check("period_distinct", distinct, 255);

    // randomized traffic
    repeat (1500) begin
      bus.EN        = ($urandom_range(0, 19) != 0);
      bus.hold      = ($urandom_range(0, 5) == 0);
      bus.seed_load = ($urandom_range(0, 15) == 0);
      bus.seed_in   = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
